// File: rtl/timer_display_scan_pkg.sv
// Shared types and constants for the three-digit seven-segment scanner.
// Segment patterns are active-low, bit order g..a.
package timer_display_pkg;

    typedef enum logic [1:0] {
        SLOT_M0 = 2'd0,
        SLOT_S1 = 2'd1,
        SLOT_S0 = 2'd2
    } slot_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [2:0] ANODE_OFF = 3'b111;

    // A BCD digit carried on a 6-bit bus is only meaningful up to 9.
    function automatic logic digit_bad(input logic [5:0] d);
        return (d > 6'd9);
    endfunction

endpackage

// File: rtl/timer_display_scan_if.sv
// Timer-to-display bundle: BCD digits and run flag in, multiplexed display lines out.
// master = playback timer side, slave = display scanner.
interface timer_display_scan_if;
    logic       count;
    logic [5:0] seconds0;
    logic [5:0] seconds1;
    logic [5:0] minutes0;
    logic [2:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       range_err;

    modport master (
        output count, seconds0, seconds1, minutes0,
        input  anode, seg, dp, range_err
    );

    modport slave (
        input  count, seconds0, seconds1, minutes0,
        output anode, seg, dp, range_err
    );
endinterface

// File: rtl/timer_display_scan_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; anything above 9 shows a dash.
module seg7_decode
    import timer_display_pkg::*;
(
    input  logic [5:0] digit,
    output logic [6:0] seg_n
);

    // Pattern lookup, dash for every out-of-range code.
    always_comb begin
        case (digit)
            6'd0:    seg_n = SEG_0;
            6'd1:    seg_n = SEG_1;
            6'd2:    seg_n = SEG_2;
            6'd3:    seg_n = SEG_3;
            6'd4:    seg_n = SEG_4;
            6'd5:    seg_n = SEG_5;
            6'd6:    seg_n = SEG_6;
            6'd7:    seg_n = SEG_7;
            6'd8:    seg_n = SEG_8;
            6'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/timer_display_scan.sv
// Three-digit common-anode display scanner with per-frame snapshot and sticky range error.
// Optional pause blink is built when TIMER_DISPLAY_BLINK_EN is defined.
module timer_display_scan
    import timer_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned BLINK_DIV    = 25000000
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_display_scan_if.slave  bus
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    slot_e            slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       snap_m0_q, snap_m0_d;
    logic [5:0]       snap_s1_q, snap_s1_d;
    logic [5:0]       snap_s0_q, snap_s0_d;
    logic             range_err_q, range_err_d;
    logic [2:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             load_s;
    logic             lit_s;
    logic             show_s;
    logic [5:0]       sel_digit_s;
    logic [2:0]       scan_anode_s;
    logic [6:0]       dec_seg_s;

    // Slot counter and FSM: advance the slot when the counter wraps.
    always_comb begin
        slot_d = slot_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (slot_q)
                SLOT_M0: slot_d = SLOT_S1;
                SLOT_S1: slot_d = SLOT_S0;
                SLOT_S0: slot_d = SLOT_M0;
                default: slot_d = SLOT_M0;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Snapshot all digits at the start of M0 so a frame never mixes old and new values.
    always_comb begin
        load_s = (slot_q == SLOT_M0) && (cnt_q == '0);
        if (load_s) begin
            snap_m0_d = bus.minutes0;
            snap_s1_d = bus.seconds1;
            snap_s0_d = bus.seconds0;
        end else begin
            snap_m0_d = snap_m0_q;
            snap_s1_d = snap_s1_q;
            snap_s0_d = snap_s0_q;
        end
    end

    // Sticky range error, evaluated on the registered snapshot.
    always_comb begin
        range_err_d = range_err_q | digit_bad(snap_m0_q)
                                  | digit_bad(snap_s1_q)
                                  | digit_bad(snap_s0_q);
    end

    // Per-slot digit and anode selection.
    always_comb begin
        case (slot_q)
            SLOT_M0: begin
                sel_digit_s  = snap_m0_q;
                scan_anode_s = 3'b011;
            end
            SLOT_S1: begin
                sel_digit_s  = snap_s1_q;
                scan_anode_s = 3'b101;
            end
            SLOT_S0: begin
                sel_digit_s  = snap_s0_q;
                scan_anode_s = 3'b110;
            end
            default: begin
                sel_digit_s  = 6'd0;
                scan_anode_s = ANODE_OFF;
            end
        endcase
    end

    seg7_decode u_decode (
        .digit (sel_digit_s),
        .seg_n (dec_seg_s)
    );

`ifdef TIMER_DISPLAY_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic               phase_q, phase_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;

    // Blink only while paused; resuming forces the on phase immediately.
    always_comb begin
        if (bus.count) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + BLINK_W'(1);
            phase_d = phase_q;
        end
        show_s = phase_d;
    end

    // Blink phase and half-period counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end
`else
    localparam int unsigned UNUSED_BLINK_DIV = BLINK_DIV;
    logic unused_count_s;
    assign unused_count_s = bus.count;

    // Without blink the scan is always shown.
    always_comb begin
        show_s = 1'b1;
    end
`endif

    // Next output values; the blank window at the start of each slot stops ghosting.
    always_comb begin
        lit_s = (cnt_q >= CNT_BLANK);
        if (lit_s) begin
            anode_d = show_s ? scan_anode_s : ANODE_OFF;
            seg_d   = dec_seg_s;
            dp_d    = ~(show_s && (slot_q == SLOT_M0));
        end else begin
            anode_d = ANODE_OFF;
            seg_d   = SEG_BLANK;
            dp_d    = 1'b1;
        end
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_q      <= SLOT_M0;
            cnt_q       <= '0;
            snap_m0_q   <= 6'd0;
            snap_s1_q   <= 6'd0;
            snap_s0_q   <= 6'd0;
            range_err_q <= 1'b0;
            anode_q     <= ANODE_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            snap_m0_q   <= snap_m0_d;
            snap_s1_q   <= snap_s1_d;
            snap_s0_q   <= snap_s0_d;
            range_err_q <= range_err_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.anode     = anode_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.range_err = range_err_q;

endmodule
